// File: rtl/alu_pipe_param.sv
// Parametrised execute-stage ALU: registered write-back, persistent flags, branch
// redirect, an iterative shift-add multiplier with back-pressure, and a HALT state.
module alu_pipe_param #(
  parameter int DW  = 16,
  parameter int AW  = 4,
  parameter int PCW = 12,
  parameter int SHW = $clog2(DW)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic [3:0]     op_i,
  input  logic [AW-1:0]  adr_i,
  input  logic [DW-1:0]  a_i,
  input  logic [DW-1:0]  b_i,
  input  logic [PCW-1:0] tgt_i,
  input  logic           haz_i,
  output logic           wr_ena_o,
  output logic [AW-1:0]  wr_adr_o,
  output logic [DW-1:0]  wr_data_o,
  output logic           flag_gt_o,
  output logic           flag_lt_o,
  output logic           flag_eq_o,
  output logic           flag_c_o,
  output logic           br_take_o,
  output logic [PCW-1:0] br_tgt_o,
  output logic           haz_o,
  output logic           halt_o
);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MOV = 4'd2,  OP_CMP = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4,  OP_AND = 4'd5,  OP_XOR = 4'd6,  OP_INC = 4'd7;
  localparam logic [3:0] OP_DEC = 4'd8,  OP_JMP = 4'd9,  OP_JGT = 4'd10, OP_JEQ = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12, OP_SHL = 4'd13, OP_SHR = 4'd14, OP_END = 4'd15;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_HALT = 2'd2} state_t;

  state_t         state_q, state_d;
  logic           wr_ena_q, wr_ena_d;
  logic [AW-1:0]  wr_adr_q, wr_adr_d;
  logic [DW-1:0]  wr_data_q, wr_data_d;
  logic           br_take_q, br_take_d;
  logic [PCW-1:0] br_tgt_q, br_tgt_d;
  logic           haz_q, haz_d;
  logic [3:0]     flags_q, flags_d;  // {gt, lt, eq, c}
  logic [DW-1:0]  mcand_q, mplier_q, acc_q;
  logic [SHW-1:0] cnt_q;
  logic [AW-1:0]  madr_q;
  logic           mhaz_q;
  logic           mul_wb_q;
  logic           mul_load, wb;

  logic           accept, mul_last;
  logic [DW:0]    add_w, sub_w;
  logic [DW-1:0]  mul_sum;

  assign accept   = valid_i && ready_o;
  assign add_w    = {1'b0, a_i} + {1'b0, b_i};
  assign sub_w    = {1'b0, a_i} - {1'b0, b_i};
  assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last = (state_q == S_MUL) && (cnt_q == SHW'(DW - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (accept && op_i == OP_MUL)      state_d = S_MUL;
        else if (accept && op_i == OP_END) state_d = S_HALT;
        else                               state_d = S_IDLE;
      end
      S_MUL:   state_d = mul_last ? S_IDLE : S_MUL;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; the multiplier result cycle still holds off new work
  always_comb begin
    ready_o = (state_q == S_IDLE) && !mul_wb_q;
    halt_o  = (state_q == S_HALT);
  end

  always_comb begin
    wr_ena_d  = 1'b0;
    wr_adr_d  = '0;
    wr_data_d = '0;
    br_take_d = 1'b0;
    br_tgt_d  = '0;
    haz_d     = 1'b0;
    flags_d   = flags_q;
    mul_load  = 1'b0;
    wb        = 1'b0;
    if (mul_last) begin
      wr_ena_d  = 1'b1;
      wr_adr_d  = madr_q;
      wr_data_d = mul_sum;
      haz_d     = mhaz_q;
    end else if (accept) begin
      haz_d = haz_i;
      case (op_i)
        OP_ADD: begin wb = 1'b1; wr_data_d = add_w[DW-1:0]; flags_d[0] = add_w[DW]; end
        OP_SUB: begin wb = 1'b1; wr_data_d = sub_w[DW-1:0]; flags_d[0] = sub_w[DW]; end
        OP_MOV: begin wb = 1'b1; wr_data_d = b_i; end
        OP_CMP: flags_d[3:1] = {a_i > b_i, a_i < b_i, a_i == b_i};
        OP_OR:  begin wb = 1'b1; wr_data_d = a_i | b_i; end
        OP_AND: begin wb = 1'b1; wr_data_d = a_i & b_i; end
        OP_XOR: begin wb = 1'b1; wr_data_d = a_i ^ b_i; end
        OP_INC: begin wb = 1'b1; wr_data_d = b_i + DW'(1); end
        OP_DEC: begin wb = 1'b1; wr_data_d = b_i - DW'(1); end
        OP_JMP: br_take_d = 1'b1;
        OP_JGT: br_take_d = flags_q[3];
        OP_JEQ: br_take_d = flags_q[1];
        OP_MUL: begin haz_d = 1'b0; mul_load = 1'b1; end
        OP_SHL: begin wb = 1'b1; wr_data_d = a_i << b_i[SHW-1:0]; end
        OP_SHR: begin wb = 1'b1; wr_data_d = a_i >> b_i[SHW-1:0]; end
        default: haz_d = 1'b0;
      endcase
      if (wb) begin
        wr_ena_d = 1'b1;
        wr_adr_d = adr_i;
      end
      if (br_take_d) br_tgt_d = tgt_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ena_q  <= 1'b0;
      wr_adr_q  <= '0;
      wr_data_q <= '0;
      br_take_q <= 1'b0;
      br_tgt_q  <= '0;
      haz_q     <= 1'b0;
      flags_q   <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      madr_q    <= '0;
      mhaz_q    <= 1'b0;
      mul_wb_q  <= 1'b0;
    end else begin
      wr_ena_q  <= wr_ena_d;
      wr_adr_q  <= wr_adr_d;
      wr_data_q <= wr_data_d;
      br_take_q <= br_take_d;
      br_tgt_q  <= br_tgt_d;
      haz_q     <= haz_d;
      flags_q   <= flags_d;
      mul_wb_q  <= mul_last;
      if (mul_load) begin
        mcand_q  <= a_i;
        mplier_q <= b_i;
        acc_q    <= '0;
        cnt_q    <= '0;
        madr_q   <= adr_i;
        mhaz_q   <= haz_i;
      end else if (state_q == S_MUL) begin
        // One shift-add step: multiplicand walks left, multiplier bits walk right
        acc_q    <= mul_sum;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + SHW'(1);
      end
    end
  end

  assign wr_ena_o  = wr_ena_q;
  assign wr_adr_o  = wr_adr_q;
  assign wr_data_o = wr_data_q;
  assign br_take_o = br_take_q;
  assign br_tgt_o  = br_tgt_q;
  assign haz_o     = haz_q;
  assign {flag_gt_o, flag_lt_o, flag_eq_o, flag_c_o} = flags_q;

endmodule
